// File: rtl/snake_pkg.sv
// Shared definitions for the snake body controller: headings, FSM states,
// {x,y} word packing and the reverse-heading helper.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DEAD  = 3'd5
  } state_e;

  // Words are {x,y} with y in the low y_w bits; callers size-cast the result.
  function automatic logic [31:0] pack_xy(input logic [31:0] x, input logic [31:0] y,
                                          input int unsigned y_w);
    return (x << y_w) | y;
  endfunction

  function automatic logic [31:0] unpack_x(input logic [31:0] word, input int unsigned y_w);
    return word >> y_w;
  endfunction

  function automatic logic [31:0] unpack_y(input logic [31:0] word, input int unsigned y_w);
    return word & ((32'd1 << y_w) - 32'd1);
  endfunction

  // Up<->down and right<->left differ only in bit 1 of the encoding.
  function automatic logic [1:0] reverse_dir(input logic [1:0] dir);
    return dir ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator: filters reversals and wraps at the
// grid edges.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int X_W    = 6,
  parameter int Y_W    = 5,
  parameter int GRID_W = 40,
  parameter int GRID_H = 30
) (
  input  logic [X_W-1:0] head_x_i,
  input  logic [Y_W-1:0] head_y_i,
  input  logic [1:0]     cur_dir_i,
  input  logic [1:0]     req_dir_i,
  output logic [1:0]     eff_dir_o,
  output logic [X_W-1:0] next_x_o,
  output logic [Y_W-1:0] next_y_o
);

  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

  // Effective heading and wrapped head position one cell ahead.
  always_comb begin
    if (req_dir_i == reverse_dir(cur_dir_i)) begin
      eff_dir_o = cur_dir_i;
    end else begin
      eff_dir_o = req_dir_i;
    end
    next_x_o = head_x_i;
    next_y_o = head_y_i;
    case (eff_dir_o)
      DIR_UP: begin
        if (head_y_i == Y_W'(0)) next_y_o = Y_MAX;
        else next_y_o = head_y_i - Y_W'(1);
      end
      DIR_RIGHT: begin
        if (head_x_i == X_MAX) next_x_o = X_W'(0);
        else next_x_o = head_x_i + X_W'(1);
      end
      DIR_DOWN: begin
        if (head_y_i == Y_MAX) next_y_o = Y_W'(0);
        else next_y_o = head_y_i + Y_W'(1);
      end
      DIR_LEFT: begin
        if (head_x_i == X_W'(0)) next_x_o = X_MAX;
        else next_x_o = head_x_i - X_W'(1);
      end
      default: begin
        next_x_o = head_x_i;
        next_y_o = head_y_i;
      end
    endcase
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body owner: keeps the body as a ring buffer in a single-port sram,
// scans it for self-collision on every tick and commits the new head.
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int X_W        = 6,
  parameter int Y_W        = 5,
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int INIT_LEN   = 3,
  parameter int INIT_X     = 20,
  parameter int INIT_Y     = 15
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic                  i_tick,
  input  logic [1:0]            i_dir,
  input  logic                  i_grow,
  input  logic                  i_restart,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_write,
  output logic [X_W+Y_W-1:0]    o_wdata,
  input  logic [X_W+Y_W-1:0]    i_rdata,
  output logic [X_W-1:0]        o_head_x,
  output logic [Y_W-1:0]        o_head_y,
  output logic [1:0]            o_dir,
  output logic [ADDR_WIDTH:0]   o_len,
  output logic                  o_busy,
  output logic                  o_step_done,
  output logic                  o_dead
);

  localparam int DW = X_W + Y_W;
  localparam int AW = ADDR_WIDTH;
  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [X_W-1:0]  head_x_q, head_x_d;
  logic [Y_W-1:0]  head_y_q, head_y_d;
  logic [1:0]      dir_q, dir_d;
  logic [LW-1:0]   len_q, len_d;
  logic            step_done_q, step_done_d;
  logic            dead_q, dead_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW-1:0]   hptr_q, hptr_d;
  logic [X_W-1:0]  nx_q, nx_d;
  logic [Y_W-1:0]  ny_q, ny_d;
  logic [1:0]      ndir_q, ndir_d;
  logic            grow_q, grow_d;
  logic            hit_q, hit_d;
  logic            rvalid_q, rvalid_d;
  // Shared counter: init write index in INIT, reads still to issue in SCAN.
  logic [LW-1:0]   cnt_q, cnt_d;

  logic [1:0]      eff_dir_s;
  logic [X_W-1:0]  nx_s;
  logic [Y_W-1:0]  ny_s;
  logic            grow_eff_s;
  logic [DW-1:0]   cand_s;
  logic [X_W-1:0]  init_x_s;
  logic [DW-1:0]   init_word_s;
  logic            hit_now_s;

  snake_next_head #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_next_head (
    .head_x_i  (head_x_q),
    .head_y_i  (head_y_q),
    .cur_dir_i (dir_q),
    .req_dir_i (i_dir),
    .eff_dir_o (eff_dir_s),
    .next_x_o  (nx_s),
    .next_y_o  (ny_s)
  );

  assign grow_eff_s  = i_grow && (len_q != DEPTH_L);
  assign cand_s      = DW'(pack_xy(32'(nx_q), 32'(ny_q), Y_W));
  assign init_x_s    = X_W'(INIT_X - INIT_LEN + 1) + X_W'(cnt_q);
  assign init_word_s = DW'(pack_xy(32'(init_x_s), 32'(INIT_Y), Y_W));
  // Read data returned this cycle belongs to an address issued during SCAN.
  assign hit_now_s   = rvalid_q && (i_rdata == cand_s);

  // Next-state logic for the body FSM and every output register.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = 1'b0;
    wdata_d     = wdata_q;
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    dir_d       = dir_q;
    len_d       = len_q;
    step_done_d = 1'b0;
    dead_d      = dead_q;
    tail_d      = tail_q;
    hptr_d      = hptr_q;
    nx_d        = nx_q;
    ny_d        = ny_q;
    ndir_d      = ndir_q;
    grow_d      = grow_q;
    hit_d       = hit_q | hit_now_s;
    rvalid_d    = (state_q == ST_SCAN);
    cnt_d       = cnt_q;

    if (i_restart) begin
      state_d = ST_INIT;
      cnt_d   = LW'(0);
      dead_d  = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (cnt_q < LW'(INIT_LEN)) begin
            addr_d  = AW'(cnt_q);
            write_d = 1'b1;
            wdata_d = init_word_s;
            cnt_d   = cnt_q + LW'(1);
          end else begin
            state_d  = ST_IDLE;
            len_d    = LW'(INIT_LEN);
            tail_d   = AW'(0);
            hptr_d   = AW'(INIT_LEN - 1);
            dir_d    = DIR_RIGHT;
            dead_d   = 1'b0;
            head_x_d = X_W'(INIT_X);
            head_y_d = Y_W'(INIT_Y);
          end
        end
        ST_IDLE: begin
          if (i_tick) begin
            state_d = ST_SCAN;
            grow_d  = grow_eff_s;
            ndir_d  = eff_dir_s;
            nx_d    = nx_s;
            ny_d    = ny_s;
            hit_d   = 1'b0;
            // The vacating tail cell is not an obstacle unless the snake grows.
            if (grow_eff_s) begin
              cnt_d  = len_q;
              addr_d = tail_q;
            end else begin
              cnt_d  = len_q - LW'(1);
              addr_d = tail_q + AW'(1);
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (cnt_q == LW'(1)) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
            cnt_d  = cnt_q - LW'(1);
          end
        end
        ST_DRAIN: begin
          if (hit_d) begin
            state_d     = ST_DEAD;
            dead_d      = 1'b1;
            step_done_d = 1'b1;
          end else begin
            state_d = ST_WRITE;
            write_d = 1'b1;
            addr_d  = hptr_q + AW'(1);
            wdata_d = cand_s;
          end
        end
        ST_WRITE: begin
          state_d     = ST_IDLE;
          hptr_d      = hptr_q + AW'(1);
          head_x_d    = nx_q;
          head_y_d    = ny_q;
          dir_d       = ndir_q;
          step_done_d = 1'b1;
          if (grow_q) begin
            len_d = len_q + LW'(1);
          end else begin
            tail_d = tail_q + AW'(1);
          end
        end
        ST_DEAD: begin
          state_d = ST_DEAD;
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = LW'(0);
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      addr_q      <= AW'(0);
      write_q     <= 1'b0;
      wdata_q     <= DW'(0);
      head_x_q    <= X_W'(INIT_X);
      head_y_q    <= Y_W'(INIT_Y);
      dir_q       <= DIR_RIGHT;
      len_q       <= LW'(0);
      step_done_q <= 1'b0;
      dead_q      <= 1'b0;
      tail_q      <= AW'(0);
      hptr_q      <= AW'(0);
      nx_q        <= X_W'(0);
      ny_q        <= Y_W'(0);
      ndir_q      <= DIR_RIGHT;
      grow_q      <= 1'b0;
      hit_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      cnt_q       <= LW'(0);
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      dir_q       <= dir_d;
      len_q       <= len_d;
      step_done_q <= step_done_d;
      dead_q      <= dead_d;
      tail_q      <= tail_d;
      hptr_q      <= hptr_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      ndir_q      <= ndir_d;
      grow_q      <= grow_d;
      hit_q       <= hit_d;
      rvalid_q    <= rvalid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_addr      = addr_q;
  assign o_write     = write_q;
  assign o_wdata     = wdata_q;
  assign o_head_x    = head_x_q;
  assign o_head_y    = head_y_q;
  assign o_dir       = dir_q;
  assign o_len       = len_q;
  assign o_step_done = step_done_q;
  assign o_dead      = dead_q;
  assign o_busy      = (state_q != ST_IDLE) && (state_q != ST_DEAD);

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Self-checking bench for snake_body_ctrl: sram model plus a queue-based
// reference model of the snake driven by directed and random steps.
module tb_snake_body_ctrl;

  localparam int AW       = 8;
  localparam int X_W      = 6;
  localparam int Y_W      = 5;
  localparam int GRID_W   = 40;
  localparam int GRID_H   = 30;
  localparam int INIT_LEN = 3;
  localparam int INIT_X   = 20;
  localparam int INIT_Y   = 15;
  localparam int DW       = X_W + Y_W;
  localparam int LW       = AW + 1;
  localparam int DEPTH    = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_tick = 1'b0;
  logic [1:0]    i_dir = 2'd1;
  logic          i_grow = 1'b0;
  logic          i_restart = 1'b0;
  logic [DW-1:0] i_rdata = '0;
  logic [AW-1:0] o_addr;
  logic          o_write;
  logic [DW-1:0] o_wdata;
  logic [X_W-1:0] o_head_x;
  logic [Y_W-1:0] o_head_y;
  logic [1:0]    o_dir;
  logic [LW-1:0] o_len;
  logic          o_busy, o_step_done, o_dead;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [DEPTH];
  int            wr_cnt = 0;
  logic [AW-1:0] last_waddr = '0;
  logic [DW-1:0] last_wdata = '0;

  // reference model: body[0] is the tail, body[$] the head
  logic [DW-1:0] body[$];
  int m_dir, m_ptr;
  bit m_dead;

  snake_body_ctrl #(
    .ADDR_WIDTH(AW), .X_W(X_W), .Y_W(Y_W), .GRID_W(GRID_W), .GRID_H(GRID_H),
    .INIT_LEN(INIT_LEN), .INIT_X(INIT_X), .INIT_Y(INIT_Y)
  ) dut (
    .i_clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_dir(i_dir), .i_grow(i_grow),
    .i_restart(i_restart), .o_addr(o_addr), .o_write(o_write), .o_wdata(o_wdata),
    .i_rdata(i_rdata), .o_head_x(o_head_x), .o_head_y(o_head_y), .o_dir(o_dir),
    .o_len(o_len), .o_busy(o_busy), .o_step_done(o_step_done), .o_dead(o_dead)
  );

  always #5 clk = ~clk;

  // single-port sram with one-cycle read latency
  always @(posedge clk) begin
    if (o_write) begin
      mem[o_addr] <= o_wdata;
      wr_cnt      <= wr_cnt + 1;
      last_waddr  <= o_addr;
      last_wdata  <= o_wdata;
    end else begin
      i_rdata <= mem[o_addr];
    end
  end

  function automatic logic [DW-1:0] xy(input int x, input int y);
    logic [X_W-1:0] xs;
    logic [Y_W-1:0] ys;
    xs = X_W'(x);
    ys = Y_W'(y);
    return {xs, ys};
  endfunction

  task automatic model_init();
    body.delete();
    for (int i = 0; i < INIT_LEN; i++) body.push_back(xy(INIT_X - INIT_LEN + 1 + i, INIT_Y));
    m_ptr  = INIT_LEN - 1;
    m_dir  = 1;
    m_dead = 1'b0;
  endtask

  task automatic model_step(input int d, input bit grow_in, output int exp_lat, output bit hit);
    int eff, hx, hy, nx, ny, n, first;
    bit g;
    logic [DW-1:0] h;
    eff = (d == (m_dir + 2) % 4) ? m_dir : d;
    h   = body[body.size() - 1];
    hx  = int'(h[DW-1:Y_W]);
    hy  = int'(h[Y_W-1:0]);
    nx  = hx;
    ny  = hy;
    case (eff)
      0:       ny = (hy + GRID_H - 1) % GRID_H;
      1:       nx = (hx + 1) % GRID_W;
      2:       ny = (hy + 1) % GRID_H;
      default: nx = (hx + GRID_W - 1) % GRID_W;
    endcase
    g     = grow_in && (body.size() < DEPTH);
    n     = g ? body.size() : body.size() - 1;
    first = g ? 0 : 1;
    hit   = 1'b0;
    for (int i = first; i < body.size(); i++) if (body[i] == xy(nx, ny)) hit = 1'b1;
    if (hit) begin
      m_dead  = 1'b1;
      exp_lat = n + 2;
    end else begin
      body.push_back(xy(nx, ny));
      if (!g) void'(body.pop_front());
      m_ptr   = (m_ptr + 1) % DEPTH;
      m_dir   = eff;
      exp_lat = n + 3;
    end
  endtask

  // Starts at a negedge; returns at the negedge where o_step_done is seen.
  task automatic drive_step(input int d, input bit g, input bit noise, output int lat);
    i_tick = 1'b1;
    i_dir  = 2'(d);
    i_grow = g;
    lat    = -1;
    for (int k = 1; k <= DEPTH + 10; k++) begin
      @(negedge clk);
      if (k == 1) i_tick = 1'b0;
      if (noise && k == 2) begin
        i_tick = 1'b1;
        i_dir  = 2'($urandom_range(0, 3));
        i_grow = 1'b1;
      end
      if (k == 3) begin
        i_tick = 1'b0;
        i_grow = 1'b0;
      end
      if (o_step_done) begin
        lat = k;
        break;
      end
    end
    i_tick = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (!o_busy) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic pulse_restart(input bit with_tick, output int cyc);
    i_restart = 1'b1;
    i_tick    = with_tick;
    i_dir     = 2'($urandom_range(0, 3));
    @(negedge clk);
    i_restart = 1'b0;
    i_tick    = 1'b0;
    wait_idle(cyc);
  endtask

  task automatic test_reset();
    int cyc, w0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", o_addr); end
    checks++; if (o_write !== 1'b0) begin failures++; $display("FAIL reset_write got=%0b exp=0", o_write); end
    checks++; if (o_wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", o_wdata); end
    checks++; if (o_head_x !== X_W'(INIT_X) || o_head_y !== Y_W'(INIT_Y)) begin failures++; $display("FAIL reset_head got=(%0d,%0d) exp=(%0d,%0d)", o_head_x, o_head_y, INIT_X, INIT_Y); end
    checks++; if (o_dir !== 2'd1) begin failures++; $display("FAIL reset_dir got=%0d exp=1", o_dir); end
    checks++; if (o_len !== '0) begin failures++; $display("FAIL reset_len got=%0d exp=0", o_len); end
    checks++; if (o_step_done !== 1'b0 || o_dead !== 1'b0) begin failures++; $display("FAIL reset_flags got done=%0b dead=%0b exp=0,0", o_step_done, o_dead); end
    w0 = wr_cnt;
    rst_n = 1'b1;
    wait_idle(cyc);
    checks++; if (cyc < 0) begin failures++; $display("FAIL init_timeout got=busy exp=idle"); end
    checks++; if (wr_cnt - w0 != INIT_LEN) begin failures++; $display("FAIL init_writes got=%0d exp=%0d", wr_cnt - w0, INIT_LEN); end
    for (int i = 0; i < INIT_LEN; i++) begin
      checks++; if (mem[i] !== xy(INIT_X - INIT_LEN + 1 + i, INIT_Y)) begin failures++; $display("FAIL init_mem%0d got=%0h exp=%0h", i, mem[i], xy(INIT_X - INIT_LEN + 1 + i, INIT_Y)); end
    end
    checks++; if (o_len !== LW'(INIT_LEN) || o_head_x !== 6'd20 || o_head_y !== 5'd15) begin failures++; $display("FAIL init_state got len=%0d head=(%0d,%0d) exp len=3 head=(20,15)", o_len, o_head_x, o_head_y); end
    model_init();
  endtask

  task automatic test_basic_step();
    int w0, el, lat;
    bit eh;
    w0 = wr_cnt;
    model_step(1, 1'b0, el, eh);
    drive_step(1, 1'b0, 1'b0, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL step_latency got=%0d exp=5", lat); end
    checks++; if (o_head_x !== 6'd21 || o_head_y !== 5'd15 || o_len !== 9'd3) begin failures++; $display("FAIL step_state got head=(%0d,%0d) len=%0d exp (21,15) len=3", o_head_x, o_head_y, o_len); end
    checks++; if (wr_cnt - w0 != 1 || last_waddr !== 8'd3 || last_wdata !== xy(21, 15)) begin failures++; $display("FAIL step_write got n=%0d addr=%0d data=%0h exp n=1 addr=3 data=%0h", wr_cnt - w0, last_waddr, last_wdata, xy(21, 15)); end
  endtask

  task automatic test_reversal();
    int el, lat;
    bit eh;
    model_step(3, 1'b0, el, eh);
    drive_step(3, 1'b0, 1'b0, lat);
    checks++; if (o_head_x !== 6'd22 || o_head_y !== 5'd15 || o_dir !== 2'd1 || lat != 5) begin failures++; $display("FAIL reversal got head=(%0d,%0d) dir=%0d lat=%0d exp (22,15) dir=1 lat=5", o_head_x, o_head_y, o_dir, lat); end
  endtask

  task automatic test_wrap_x();
    int el, lat;
    bit eh;
    for (int i = 0; i < 18; i++) begin
      model_step(1, 1'b0, el, eh);
      drive_step(1, 1'b0, 1'b0, lat);
      checks++; if (lat != el) begin failures++; $display("FAIL wrap_latency got=%0d exp=%0d", lat, el); end
    end
    checks++; if (o_head_x !== 6'd0 || o_head_y !== 5'd15) begin failures++; $display("FAIL wrap_x got=(%0d,%0d) exp=(0,15)", o_head_x, o_head_y); end
  endtask

  task automatic test_collision();
    int dirs[5] = '{1, 1, 2, 3, 0};
    bit grows[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int cyc, el, lat, w0;
    bit eh;
    pulse_restart(1'b0, cyc);
    model_init();
    checks++; if (cyc < 0 || o_len !== 9'd3) begin failures++; $display("FAIL coll_restart got len=%0d cyc=%0d exp len=3", o_len, cyc); end
    for (int i = 0; i < 5; i++) begin
      w0 = wr_cnt;
      model_step(dirs[i], grows[i], el, eh);
      drive_step(dirs[i], grows[i], 1'b0, lat);
      checks++; if (lat != el) begin failures++; $display("FAIL coll_latency%0d got=%0d exp=%0d", i, lat, el); end
      if (i == 1) begin
        checks++; if (o_len !== 9'd5 || o_head_x !== 6'd22) begin failures++; $display("FAIL coll_grow got len=%0d x=%0d exp len=5 x=22", o_len, o_head_x); end
      end
    end
    checks++; if (o_dead !== 1'b1 || o_len !== 9'd5 || lat != 6) begin failures++; $display("FAIL coll_dead got dead=%0b len=%0d lat=%0d exp 1,5,6", o_dead, o_len, lat); end
    checks++; if (wr_cnt != w0 || o_head_x !== 6'd21 || o_head_y !== 5'd16) begin failures++; $display("FAIL coll_nowrite got writes=%0d head=(%0d,%0d) exp 0 (21,16)", wr_cnt - w0, o_head_x, o_head_y); end
    @(negedge clk);
    checks++; if (o_step_done !== 1'b0 || o_busy !== 1'b0 || o_dead !== 1'b1) begin failures++; $display("FAIL dead_hold got done=%0b busy=%0b dead=%0b exp 0,0,1", o_step_done, o_busy, o_dead); end
  endtask

  task automatic test_restart();
    int cyc, w0;
    w0 = wr_cnt;
    pulse_restart(1'b1, cyc);
    model_init();
    checks++; if (cyc < 0 || o_dead !== 1'b0 || o_len !== 9'd3) begin failures++; $display("FAIL restart_state got dead=%0b len=%0d cyc=%0d exp 0,3", o_dead, o_len, cyc); end
    checks++; if (wr_cnt - w0 != INIT_LEN) begin failures++; $display("FAIL restart_writes got=%0d exp=%0d", wr_cnt - w0, INIT_LEN); end
    for (int i = 0; i < INIT_LEN; i++) begin
      checks++; if (mem[i] !== xy(INIT_X - INIT_LEN + 1 + i, INIT_Y)) begin failures++; $display("FAIL restart_mem%0d got=%0h exp=%0h", i, mem[i], xy(INIT_X - INIT_LEN + 1 + i, INIT_Y)); end
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    i_tick = 1'b1;
    i_dir  = 2'd2;
    @(negedge clk);
    i_tick = 1'b0;
    checks++; if (o_busy !== 1'b1 || o_write !== 1'b0) begin failures++; $display("FAIL scan_busy got busy=%0b write=%0b exp 1,0", o_busy, o_write); end
    rst_n = 1'b0;
    #1;
    checks++; if (o_write !== 1'b0 || o_len !== '0 || o_addr !== '0 || o_step_done !== 1'b0) begin failures++; $display("FAIL async_reset got write=%0b len=%0d addr=%0d exp 0,0,0", o_write, o_len, o_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(cyc);
    model_init();
    checks++; if (cyc < 0 || o_len !== 9'd3 || o_head_x !== 6'd20) begin failures++; $display("FAIL reinit got len=%0d x=%0d exp 3,20", o_len, o_head_x); end
  endtask

  task automatic test_random(input int steps, input bit allow_grow);
    int d, el, lat, w0, cyc;
    bit g, noise, eh;
    for (int s = 0; s < steps; s++) begin
      d     = int'($urandom_range(0, 3));
      g     = allow_grow && ($urandom_range(0, 5) == 0);
      noise = ($urandom_range(0, 3) == 0);
      w0    = wr_cnt;
      model_step(d, g, el, eh);
      drive_step(d, g, noise, lat);
      checks++; if (lat != el) begin failures++; $display("FAIL rand_latency step=%0d got=%0d exp=%0d", s, lat, el); end
      checks++; if ({o_head_x, o_head_y} !== body[body.size() - 1] || o_len !== LW'(body.size())) begin failures++; $display("FAIL rand_state step=%0d got head=%0h len=%0d exp head=%0h len=%0d", s, {o_head_x, o_head_y}, o_len, body[body.size() - 1], body.size()); end
      checks++; if (o_dir !== 2'(m_dir) || o_dead !== m_dead) begin failures++; $display("FAIL rand_flags step=%0d got dir=%0d dead=%0b exp dir=%0d dead=%0b", s, o_dir, o_dead, m_dir, m_dead); end
      checks++; if (wr_cnt - w0 != (eh ? 0 : 1)) begin failures++; $display("FAIL rand_wrcount step=%0d got=%0d exp=%0d", s, wr_cnt - w0, eh ? 0 : 1); end
      if (!eh) begin
        checks++; if (last_waddr !== AW'(m_ptr) || last_wdata !== body[body.size() - 1]) begin failures++; $display("FAIL rand_write step=%0d got addr=%0d data=%0h exp addr=%0d data=%0h", s, last_waddr, last_wdata, m_ptr, body[body.size() - 1]); end
      end
      if (m_dead) begin
        pulse_restart(1'($urandom_range(0, 1)), cyc);
        model_init();
        checks++; if (cyc < 0 || o_dead !== 1'b0 || o_len !== LW'(INIT_LEN)) begin failures++; $display("FAIL rand_restart got dead=%0b len=%0d cyc=%0d exp 0,3", o_dead, o_len, cyc); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '1;
    test_reset();
    test_basic_step();
    test_reversal();
    test_wrap_x();
    test_collision();
    test_restart();
    test_reset_mid_scan();
    test_random(262, 1'b0);
    test_random(200, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
